// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared fetch-stage types, constants and alignment helper
package pc_fetch_pkg;
  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [1:0]  WORD_ALIGN_MASK  = 2'b11;
  function automatic logic is_aligned(input logic [31:0] a);
    return (a[1:0] & WORD_ALIGN_MASK) == 2'b00;
  endfunction
endpackage

// File: rtl/pc_fetch_retire_counter.sv
// retire_counter: 32-bit wrapping counter with synchronous reset and enable
module retire_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (en) count <= count + 32'd1;
  end
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC register and single-outstanding instruction fetch controller
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  output logic [31:0] cur_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        fault,
  output logic [31:0] retired
);
  fetch_state_e state, state_n;
  logic [31:0] pc, instr;
  logic accept, capture, aligned;
  always_comb begin
    aligned = is_aligned(next_pc);
    accept  = (state == VALID) && if_ready;
    capture = ((state == REQ) && imem_gnt && imem_rvalid) || ((state == WAIT) && imem_rvalid);
    state_n = (state == REQ)   ? (imem_gnt ? (imem_rvalid ? VALID : WAIT) : REQ) :
              (state == WAIT)  ? (imem_rvalid ? VALID : WAIT) :
              (state == VALID) ? (if_ready ? (aligned ? REQ : FAULT) : VALID) :
                                 FAULT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_n;
      if (capture) instr <= imem_rdata;
      if (accept && aligned) pc <= next_pc;
    end
  end
  // Request is gated by rst so nothing is issued while reset is held
  assign imem_req  = (state == REQ) && !rst;
  assign imem_addr = pc;
  assign cur_pc    = pc;
  assign if_pc     = pc;
  assign if_instr  = instr;
  assign if_valid  = (state == VALID);
  assign fault     = (state == FAULT);
  retire_counter u_ret (
    .clk   (clk),
    .rst   (rst),
    .en    (accept),
    .count (retired)
  );
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: randomized self-checking bench for pc_fetch against a transaction-level model
module tb_pc_fetch;
  logic        clk = 0, rst = 1;
  logic [31:0] next_pc = 0, cur_pc, imem_addr, imem_rdata = 0, if_instr, if_pc, retired;
  logic        imem_req, imem_gnt = 0, imem_rvalid = 0, if_valid, if_ready = 0, fault;
  int          cyc = 0, total = 0, bad = 0;
  logic [31:0] exp_pc, exp_ret;
  logic        exp_fault;
  pc_fetch dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .cur_pc(cur_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .fault(fault), .retired(retired)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic test_reset;
    rst = 1; imem_gnt = 0; imem_rvalid = 0; if_ready = 0;
    @(negedge clk); @(negedge clk);
    total++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL reset_ctl: req=%b valid=%b fault=%b want 0 0 0", imem_req, if_valid, fault); end
    total++; if (cur_pc !== 32'h0 || if_instr !== 32'h0 || retired !== 32'h0) begin bad++; $display("FAIL reset_regs: pc=%h instr=%h ret=%h want all 0", cur_pc, if_instr, retired); end
    rst = 0; #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL first_req: req=%b addr=%h want 1 00000000", imem_req, imem_addr); end
    exp_pc = 0; exp_ret = 0; exp_fault = 0;
  endtask
  // One fetch: grant after gd REQ cycles, data rd cycles after grant, decode stalls for stall cycles
  task automatic xact(input int gd, input int rd, input int stall, input logic [31:0] npc);
    logic [31:0] d;
    int t0;
    d = $urandom; t0 = cyc;
    for (int n = 0; n <= gd; n++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || if_valid !== 1'b0) begin bad++; $display("FAIL req: req=%b addr=%h valid=%b want 1 %h 0", imem_req, imem_addr, if_valid, exp_pc); end
      imem_gnt = (n == gd); imem_rvalid = (n == gd) && (rd == 0); imem_rdata = (n == gd) ? d : $urandom;
      @(negedge clk);
    end
    imem_gnt = 0; imem_rvalid = 0;
    for (int n = 1; n <= rd; n++) begin
      total++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL wait: req=%b valid=%b want 0 0", imem_req, if_valid); end
      imem_rvalid = (n == rd); imem_rdata = d;
      @(negedge clk);
    end
    imem_rvalid = 0;
    total++; if (if_valid !== 1'b1 || if_instr !== d || if_pc !== exp_pc) begin bad++; $display("FAIL deliver: valid=%b instr=%h pc=%h want 1 %h %h", if_valid, if_instr, if_pc, d, exp_pc); end
    total++; if (cyc - t0 !== gd + rd + 1) begin bad++; $display("FAIL latency: got %0d cycles want %0d", cyc - t0, gd + rd + 1); end
    for (int s = 0; s < stall; s++) begin
      next_pc = $urandom; imem_gnt = $urandom_range(0, 1); imem_rvalid = $urandom_range(0, 1); imem_rdata = $urandom;
      @(negedge clk);
      total++; if (if_valid !== 1'b1 || if_instr !== d || if_pc !== exp_pc || imem_req !== 1'b0) begin bad++; $display("FAIL stall: valid=%b instr=%h pc=%h req=%b want 1 %h %h 0", if_valid, if_instr, if_pc, imem_req, d, exp_pc); end
    end
    imem_gnt = 0; imem_rvalid = 0; if_ready = 1; next_pc = npc;
    @(negedge clk);
    if_ready = 0;
    exp_ret = exp_ret + 1;
    if (npc[1:0] == 2'b00) exp_pc = npc; else exp_fault = 1;
    total++; if (retired !== exp_ret || fault !== exp_fault || cur_pc !== exp_pc || imem_req !== !exp_fault) begin bad++; $display("FAIL accept: ret=%h fault=%b pc=%h req=%b want %h %b %h %b", retired, fault, cur_pc, imem_req, exp_ret, exp_fault, exp_pc, !exp_fault); end
  endtask
  task automatic test_zero_wait;
    for (int i = 0; i < 3; i++) xact(0, 0, 0, exp_pc + 32'd4);
    total++; if (retired !== 32'd3 || cur_pc !== 32'd12) begin bad++; $display("FAIL zero_wait: ret=%h pc=%h want 3 0000000c", retired, cur_pc); end
  endtask
  task automatic test_latency;
    xact(2, 3, 0, exp_pc + 32'd4);
  endtask
  task automatic test_stall;
    xact(0, 1, 4, exp_pc + 32'd4);
  endtask
  task automatic test_random;
    logic [31:0] r;
    for (int i = 0; i < 12; i++) begin
      r = $urandom;
      xact($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r & ~32'h3);
    end
  endtask
  task automatic test_wrap;
    force dut.u_ret.count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.u_ret.count;
    total++; if (retired !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preload: ret=%h want ffffffff", retired); end
    exp_ret = 32'hFFFF_FFFF;
    xact(0, 0, 0, exp_pc + 32'd4);
    total++; if (retired !== 32'h0) begin bad++; $display("FAIL wrap: ret=%h want 00000000", retired); end
  endtask
  task automatic test_branch_fault;
    xact(0, 0, 0, 32'h0000_0040);
    xact(1, 0, 0, 32'h0000_0042);
    for (int i = 0; i < 6; i++) begin
      imem_gnt = 1; imem_rvalid = 1; if_ready = $urandom_range(0, 1); next_pc = $urandom & ~32'h3;
      @(negedge clk);
      total++; if (fault !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0 || cur_pc !== 32'h40) begin bad++; $display("FAIL fault_hold: fault=%b req=%b valid=%b pc=%h want 1 0 0 00000040", fault, imem_req, if_valid, cur_pc); end
    end
    imem_gnt = 0; imem_rvalid = 0; if_ready = 0;
  endtask
  task automatic test_reset_in_wait;
    test_reset;
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 0;
    total++; if (imem_req !== 1'b1 || if_valid !== 1'b0 || if_instr !== 32'h0) begin bad++; $display("FAIL spurious: req=%b valid=%b instr=%h want 1 0 00000000", imem_req, if_valid, if_instr); end
    imem_gnt = 1;
    @(negedge clk);
    imem_gnt = 0;
    total++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL to_wait: req=%b valid=%b want 0 0", imem_req, if_valid); end
    rst = 1; imem_rvalid = 1; imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    imem_rvalid = 0; rst = 0; #1;
    total++; if (cur_pc !== 32'h0 || if_valid !== 1'b0 || if_instr !== 32'h0 || imem_req !== 1'b1) begin bad++; $display("FAIL reset_wait: pc=%h valid=%b instr=%h req=%b want 0 0 0 1", cur_pc, if_valid, if_instr, imem_req); end
    xact(1, 2, 1, 32'h0000_0100);
  endtask
  initial begin
    test_reset;
    test_zero_wait;
    test_latency;
    test_stall;
    test_random;
    test_wrap;
    test_branch_fault;
    test_reset_in_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
